// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD SPI transmitter: FSM states, word layout and
// the default SCLK divider.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } lcd_state_e;

  localparam int LCD_WORD_W          = 9;
  localparam int LCD_DC_BIT          = 8;
  localparam int LCD_CLK_DIV_DEFAULT = 2;

endpackage

// File: rtl/lcd_spi_tx.sv
// Write-only SPI mode-0 transmitter for a 9-bit LCD word (DC + byte), MSB first.
// Define LCD_SPI_CS_HOLD_EN to keep cs low between streamed words.
module lcd_spi_tx
  import lcd_pkg::*;
#(
  parameter int CLK_DIV = LCD_CLK_DIV_DEFAULT
) (
  input  logic                  clk_50MHz,
  input  logic                  rst_n,
  input  logic [LCD_WORD_W-1:0] data,
  input  logic                  en_write,
  output logic                  wr_done,
  output logic                  busy,
  output logic                  cs,
  output logic                  dc,
  output logic                  sclk,
  output logic                  mosi
);

`ifdef LCD_SPI_CS_HOLD_EN
  localparam bit CS_HOLD = 1'b1;
`else
  localparam bit CS_HOLD = 1'b0;
`endif

  localparam logic [3:0] HALF_LAST = 4'(CLK_DIV - 1);

  lcd_state_e state;
  logic [3:0] half_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;

  // NOTE: every register, including the shift register, sits on the async
  // reset so an aborted word leaves nothing behind for the next one.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      half_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      wr_done   <= 1'b0;
      busy      <= 1'b0;
      cs        <= 1'b1;
      dc        <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= 1'b0;
          busy <= 1'b0;
          if (en_write) begin
            state     <= SHIFT;
            dc        <= data[LCD_DC_BIT];
            shift_reg <= data[7:0];
            mosi      <= data[7];
            cs        <= 1'b0;
            busy      <= 1'b1;
            half_cnt  <= '0;
            bit_cnt   <= '0;
          end else begin
            cs <= 1'b1;
          end
        end

        SHIFT: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // Falling edge: the only place mosi may move.
              sclk <= 1'b0;
              if (bit_cnt == 3'd7) begin
                state   <= DONE;
                wr_done <= 1'b1;
              end else begin
                bit_cnt   <= bit_cnt + 3'd1;
                shift_reg <= {shift_reg[6:0], 1'b0};
                mosi      <= shift_reg[6];
              end
            end
          end else begin
            half_cnt <= half_cnt + 4'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          cs    <= !(CS_HOLD && en_write);
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Self-checking bench for lcd_spi_tx: three instances (CLK_DIV 2, 1, 5) observed
// cycle by cycle and compared against a word-level model of the SPI frame.
module tb_lcd_spi_tx;

  localparam int DIV_OF[3] = '{2, 1, 5};

`ifdef LCD_SPI_CS_HOLD_EN
  localparam int GAP_CS_HIGH = 0;
`else
  localparam int GAP_CS_HIGH = 1;
`endif

  typedef struct {
    logic [7:0] rx;
    logic       dc;
    int         done_k;
    int         cap_cyc;
    int         width_bad;
    int         hold_bad;
    int         idle_cs_high;
  } obs_t;

  logic       clk_50MHz = 1'b0;
  logic       rst_n     = 1'b0;
  logic [8:0] data_a [3];
  logic [2:0] en_v      = '0;
  wire  [2:0] wr_done_w, busy_w, cs_w, dc_w, sclk_w, mosi_w;

  int n_err  = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int wd_cnt[3] = '{0, 0, 0};

  always #10 clk_50MHz = ~clk_50MHz;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  always @(negedge clk_50MHz)
    for (int i = 0; i < 3; i++)
      if (wr_done_w[i] === 1'b1) wd_cnt[i] <= wd_cnt[i] + 1;

  lcd_spi_tx dut (
    .clk_50MHz(clk_50MHz), .rst_n(rst_n), .data(data_a[0]), .en_write(en_v[0]),
    .wr_done(wr_done_w[0]), .busy(busy_w[0]), .cs(cs_w[0]), .dc(dc_w[0]),
    .sclk(sclk_w[0]), .mosi(mosi_w[0])
  );

  lcd_spi_tx #(.CLK_DIV(1)) dut_d1 (
    .clk_50MHz(clk_50MHz), .rst_n(rst_n), .data(data_a[1]), .en_write(en_v[1]),
    .wr_done(wr_done_w[1]), .busy(busy_w[1]), .cs(cs_w[1]), .dc(dc_w[1]),
    .sclk(sclk_w[1]), .mosi(mosi_w[1])
  );

  lcd_spi_tx #(.CLK_DIV(5)) dut_d5 (
    .clk_50MHz(clk_50MHz), .rst_n(rst_n), .data(data_a[2]), .en_write(en_v[2]),
    .wr_done(wr_done_w[2]), .busy(busy_w[2]), .cs(cs_w[2]), .dc(dc_w[2]),
    .sclk(sclk_w[2]), .mosi(mosi_w[2])
  );

  // Waits for the next word start, then follows it to wr_done. Cycle k=1 is the
  // cycle right after the capture edge. en_mode: 0 leave en_write, 1 drop it
  // at k=1, 2 toggle it randomly while the word is in flight.
  task automatic observe_word(input int idx, input int en_mode, output obs_t o);
    int   div;
    int   run;
    bit   got;
    logic prev_sclk, prev_mosi;
    div = DIV_OF[idx];
    o.rx = '0; o.dc = 1'bx; o.done_k = -1; o.cap_cyc = -1;
    o.width_bad = 0; o.hold_bad = 0; o.idle_cs_high = 0;
    got = 1'b0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk_50MHz);
      if (busy_w[idx] === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (cs_w[idx] === 1'b1) o.idle_cs_high++;
    end
    if (!got) return;
    o.cap_cyc = cyc;
    o.dc      = dc_w[idx];
    if (cs_w[idx] !== 1'b0 || sclk_w[idx] !== 1'b0) o.hold_bad++;
    if (en_mode == 1) en_v[idx] = 1'b0;
    prev_sclk = sclk_w[idx];
    prev_mosi = mosi_w[idx];
    run = 1;
    for (int k = 2; k <= 16 * div + 40; k++) begin
      if (en_mode == 2) en_v[idx] = 1'($urandom_range(0, 1));
      @(negedge clk_50MHz);
      if (sclk_w[idx] !== prev_sclk) begin
        if (run != div) o.width_bad++;
        run = 1;
      end else begin
        run++;
      end
      if (!prev_sclk && sclk_w[idx] === 1'b1) o.rx = {o.rx[6:0], mosi_w[idx]};
      if (mosi_w[idx] !== prev_mosi && !(prev_sclk === 1'b1 && sclk_w[idx] === 1'b0))
        o.hold_bad++;
      if (dc_w[idx] !== o.dc || cs_w[idx] !== 1'b0 || busy_w[idx] !== 1'b1) o.hold_bad++;
      if (wr_done_w[idx] === 1'b1) begin
        o.done_k = k;
        break;
      end
      prev_sclk = sclk_w[idx];
      prev_mosi = mosi_w[idx];
    end
  endtask

  task automatic test_reset();
    en_v = '0;
    for (int i = 0; i < 3; i++) data_a[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({cs_w[i], sclk_w[i], mosi_w[i], dc_w[i], wr_done_w[i], busy_w[i]} !== 6'b100000) begin
        n_err++;
        $display("FAIL reset_outputs[%0d]: got %b want 100000", i,
                 {cs_w[i], sclk_w[i], mosi_w[i], dc_w[i], wr_done_w[i], busy_w[i]});
      end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk_50MHz);
    n_chk++;
    if ({cs_w[0], sclk_w[0], busy_w[0], wr_done_w[0]} !== 4'b1000) begin
      n_err++;
      $display("FAIL idle_after_reset: got %b want 1000",
               {cs_w[0], sclk_w[0], busy_w[0], wr_done_w[0]});
    end
  endtask

  task automatic test_single_command();
    obs_t o;
    int   w0;
    w0 = wd_cnt[0];
    data_a[0] = 9'h02A;
    en_v[0]   = 1'b1;
    observe_word(0, 1, o);
    n_chk++; if (o.rx !== 8'h2A) begin n_err++; $display("FAIL single_byte: got %h want 2a", o.rx); end
    n_chk++; if (o.dc !== 1'b0) begin n_err++; $display("FAIL single_dc: got %b want 0", o.dc); end
    n_chk++; if (o.done_k != 33) begin n_err++; $display("FAIL single_done_latency: got %0d want 33", o.done_k); end
    n_chk++; if (o.width_bad != 0 || o.hold_bad != 0) begin
      n_err++; $display("FAIL single_waveform: width_bad=%0d hold_bad=%0d want 0", o.width_bad, o.hold_bad);
    end
    @(negedge clk_50MHz);
    n_chk++;
    if ({cs_w[0], wr_done_w[0], busy_w[0]} !== 3'b100) begin
      n_err++; $display("FAIL single_after_done: cs/wr_done/busy got %b want 100",
                        {cs_w[0], wr_done_w[0], busy_w[0]});
    end
    repeat (40) @(negedge clk_50MHz);
    n_chk++;
    if (wd_cnt[0] - w0 != 1) begin n_err++; $display("FAIL single_done_count: got %0d want 1", wd_cnt[0] - w0); end
  endtask

  task automatic test_streaming();
    logic [8:0] words[3];
    obs_t o;
    int   w0, prev_cap;
    words = '{9'h1FF, 9'h100, 9'h155};
    w0 = wd_cnt[0];
    prev_cap = 0;
    data_a[0] = words[0];
    en_v[0]   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      observe_word(0, 0, o);
      if (i < 2) data_a[0] = words[i+1];
      else       en_v[0]   = 1'b0;
      n_chk++; if (o.rx !== words[i][7:0] || o.dc !== words[i][8]) begin
        n_err++; $display("FAIL stream_word[%0d]: got dc=%b %h want dc=%b %h", i, o.dc, o.rx, words[i][8], words[i][7:0]);
      end
      n_chk++; if (o.done_k != 33 || o.width_bad != 0 || o.hold_bad != 0) begin
        n_err++; $display("FAIL stream_timing[%0d]: done_k=%0d width_bad=%0d hold_bad=%0d want 33/0/0",
                          i, o.done_k, o.width_bad, o.hold_bad);
      end
      if (i > 0) begin
        n_chk++; if (o.cap_cyc - prev_cap != 34) begin
          n_err++; $display("FAIL stream_period[%0d]: got %0d want 34", i, o.cap_cyc - prev_cap);
        end
      end
      prev_cap = o.cap_cyc;
    end
    repeat (40) @(negedge clk_50MHz);
    n_chk++;
    if (wd_cnt[0] - w0 != 3 || busy_w[0] !== 1'b0) begin
      n_err++; $display("FAIL stream_done_count: got %0d busy=%b want 3 busy=0", wd_cnt[0] - w0, busy_w[0]);
    end
  endtask

  task automatic test_reset_mid_word();
    obs_t o;
    int   w0;
    bit   got;
    data_a[0] = 9'h0AA;
    en_v[0]   = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk_50MHz);
      if (busy_w[0] === 1'b1) begin got = 1'b1; break; end
    end
    en_v[0] = 1'b0;
    n_chk++; if (!got) begin n_err++; $display("FAIL abort_start: got no word start want busy=1"); end
    repeat (9) @(negedge clk_50MHz);
    w0 = wd_cnt[0];
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({cs_w[0], sclk_w[0], mosi_w[0], dc_w[0], wr_done_w[0], busy_w[0]} !== 6'b100000) begin
      n_err++; $display("FAIL abort_async_reset: got %b want 100000",
                        {cs_w[0], sclk_w[0], mosi_w[0], dc_w[0], wr_done_w[0], busy_w[0]});
    end
    repeat (4) @(negedge clk_50MHz);
    rst_n = 1'b1;
    repeat (40) @(negedge clk_50MHz);
    n_chk++;
    if (wd_cnt[0] != w0 || busy_w[0] !== 1'b0) begin
      n_err++; $display("FAIL abort_no_done: wr_done pulses got %0d busy=%b want 0 busy=0", wd_cnt[0] - w0, busy_w[0]);
    end
    data_a[0] = 9'h011;
    en_v[0]   = 1'b1;
    observe_word(0, 1, o);
    n_chk++; if (o.rx !== 8'h11 || o.dc !== 1'b0) begin
      n_err++; $display("FAIL abort_next_word: got dc=%b %h want dc=0 11", o.dc, o.rx);
    end
    n_chk++; if (o.done_k != 33 || o.width_bad != 0 || o.hold_bad != 0) begin
      n_err++; $display("FAIL abort_next_timing: done_k=%0d width_bad=%0d hold_bad=%0d want 33/0/0",
                        o.done_k, o.width_bad, o.hold_bad);
    end
    repeat (3) @(negedge clk_50MHz);
  endtask

  task automatic test_div_sweep();
    obs_t       o;
    int         prev_cap, div;
    logic [8:0] w;
    for (int idx = 1; idx < 3; idx++) begin
      div = DIV_OF[idx];
      prev_cap = 0;
      data_a[idx] = 9'h1C3;
      en_v[idx]   = 1'b1;
      for (int n = 0; n < 3; n++) begin
        w = data_a[idx];
        observe_word(idx, 0, o);
        if (n == 0) data_a[idx] = 9'($urandom);
        if (n == 1) en_v[idx] = 1'b0;
        n_chk++; if (o.rx !== w[7:0] || o.dc !== w[8]) begin
          n_err++; $display("FAIL div%0d_word[%0d]: got dc=%b %h want dc=%b %h", div, n, o.dc, o.rx, w[8], w[7:0]);
        end
        n_chk++; if (o.done_k != 16 * div + 1 || o.width_bad != 0 || o.hold_bad != 0) begin
          n_err++; $display("FAIL div%0d_timing[%0d]: done_k=%0d width_bad=%0d hold_bad=%0d want %0d/0/0",
                            div, n, o.done_k, o.width_bad, o.hold_bad, 16 * div + 1);
        end
        if (n == 1) begin
          n_chk++; if (o.cap_cyc - prev_cap != 16 * div + 2) begin
            n_err++; $display("FAIL div%0d_period: got %0d want %0d", div, o.cap_cyc - prev_cap, 16 * div + 2);
          end
        end
        if (n == 1) begin
          repeat (5) @(negedge clk_50MHz);
          en_v[idx] = 1'b1;
        end
        if (n == 2) en_v[idx] = 1'b0;
        prev_cap = o.cap_cyc;
      end
      repeat (5) @(negedge clk_50MHz);
    end
  endtask

  task automatic test_cs_mode();
    obs_t o;
    data_a[0] = 9'($urandom);
    en_v[0]   = 1'b1;
    observe_word(0, 0, o);
    data_a[0] = 9'($urandom);
    observe_word(0, 0, o);
    en_v[0] = 1'b0;
    n_chk++;
    if (o.idle_cs_high != GAP_CS_HIGH || o.hold_bad != 0) begin
      n_err++; $display("FAIL cs_gap: cs-high cycles got %0d hold_bad=%0d want %0d/0",
                        o.idle_cs_high, o.hold_bad, GAP_CS_HIGH);
    end
    repeat (5) @(negedge clk_50MHz);
  endtask

  task automatic test_random_stream();
    obs_t       o;
    logic [8:0] w;
    int         prev_cap;
    prev_cap = 0;
    data_a[0] = 9'($urandom);
    en_v[0]   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = data_a[0];
      observe_word(0, ($urandom_range(0, 1) == 1) ? 2 : 0, o);
      data_a[0] = 9'($urandom);
      en_v[0]   = (i < 7);
      n_chk++; if (o.rx !== w[7:0] || o.dc !== w[8] || o.done_k != 33) begin
        n_err++; $display("FAIL rand_word[%0d]: got dc=%b %h done_k=%0d want dc=%b %h 33",
                          i, o.dc, o.rx, o.done_k, w[8], w[7:0]);
      end
      n_chk++; if (o.width_bad != 0 || o.hold_bad != 0) begin
        n_err++; $display("FAIL rand_waveform[%0d]: width_bad=%0d hold_bad=%0d want 0/0", i, o.width_bad, o.hold_bad);
      end
      if (i > 0) begin
        n_chk++; if (o.cap_cyc - prev_cap != 34 || o.idle_cs_high != GAP_CS_HIGH) begin
          n_err++; $display("FAIL rand_gap[%0d]: period %0d cs-high %0d want 34 and %0d",
                            i, o.cap_cyc - prev_cap, o.idle_cs_high, GAP_CS_HIGH);
        end
      end
      prev_cap = o.cap_cyc;
    end
    repeat (5) @(negedge clk_50MHz);
  endtask

  initial begin
    test_reset();
    test_single_command();
    test_streaming();
    test_reset_mid_word();
    test_div_sweep();
    test_cs_mode();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lcd_spi_tx.md
LCD_SPI_TX -- requirements
Module: lcd_spi_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, giving the SCLK half-period in clk_50MHz cycles (legal 1..15); the default gives 12.5 MHz SCLK.
REQ-002 SHALL have port clk_50MHz  input  1  system clock, 50 MHz.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port data  input  9  word to send: bit 8 is the DC level (0 = command, 1 = data), bits 7:0 are the payload.
REQ-005 SHALL have port en_write  input  1  level request; held high means more words follow.
REQ-006 SHALL have port wr_done  output  1  one-cycle pulse marking a completed word.
REQ-007 SHALL have port busy  output  1  high from word start through the wr_done cycle.
REQ-008 SHALL have ports cs, dc, sclk, mosi  output  1 each  LCD SPI pins; cs is active-low.

Function
REQ-009 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-010 SHALL, on a clock edge in IDLE with en_write=1:
  - capture data[8:0] into dc and an 8-bit shift register;
  - drive cs=0, mosi=data[7] and sclk=0;
  - enter SHIFT.
REQ-011 SHALL sample data and en_write only in IDLE, never in SHIFT or DONE; upstream may change data on the cycle after wr_done.
REQ-012 SHALL, in SHIFT, send each bit MSB first, SPI mode 0: sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-013 SHALL update mosi only on the high-to-low sclk transition, and never while sclk is high.
REQ-014 SHALL use a half-period counter and a 3-bit bit counter; after the 8th high phase it drives sclk=0 and enters DONE.
REQ-015 SHALL drive wr_done=1 for exactly the one DONE cycle and then return to IDLE.
REQ-016 SHALL keep the word period at 16*CLK_DIV+2 cycles while en_write is held high (34 cycles at default): 1 DONE cycle, 1 IDLE cycle, then 16*CLK_DIV SHIFT cycles.
REQ-017 SHALL hold dc constant from word start through DONE.
REQ-018 SHALL ignore en_write while busy; a drop of en_write mid-word does not abort the word.
REQ-019 SHALL, in IDLE with en_write=0, hold sclk=0 and mosi at its last value, and keep busy=0.
REQ-020 SHALL drive busy=1 in SHIFT and DONE, and 0 in IDLE.

Reset
REQ-021 SHALL, while rst_n=0, force cs=1, sclk=0, mosi=0, dc=0, wr_done=0, busy=0, all counters to 0 and state IDLE, regardless of the clock.
REQ-022 SHALL abort an in-flight word on reset without emitting wr_done; after release the first word starts cleanly with a full sclk-low phase.

Configuration
REQ-023 SHALL support the macro LCD_SPI_CS_HOLD_EN:
  - Defined: cs stays 0 through the DONE and IDLE cycles between words while en_write=1, and rises only in IDLE with en_write=0.
  - Undefined: cs=1 in every IDLE cycle, giving at least one cs-high cycle between words.
  - Word period and timing are the same either way.

Structure
REQ-024 SHALL take from shared package lcd_pkg:
  - the state enum;
  - LCD_WORD_W=9;
  - LCD_DC_BIT=8;
  - the default CLK_DIV constant.
REQ-025 SHALL be a single module with no sub-module; the half-period counter is inline.

Verification
REQ-026 Single command: data=0x02A, en_write pulsed 1 cycle:
  - dc=0; mosi reads 0,0,1,0,1,0,1,0 on the rising edges;
  - wr_done exactly 33 cycles after the capture edge;
  - cs high again on the following cycle.
REQ-027 Streaming: en_write held high, data stepping 0x1FF, 0x100, 0x155 on each wr_done:
  - three words with dc=1 and bytes FF, 00, 55;
  - period 34 cycles;
  - wr_done count 3 when en_write drops after the third.
REQ-028 Reset mid-word: assert rst_n=0 at SHIFT cycle 10 of word 0x0AA:
  - outputs go to reset values immediately;
  - no wr_done;
  - the next word 0x011 after release is transmitted bit-exact.
REQ-029 Divider sweep: CLK_DIV=1 and 5, word 0x1C3:
  - sclk high/low widths 1 and 5 cycles;
  - word period 18 and 82 cycles.
REQ-030 CS mode: two back-to-back words, with and without LCD_SPI_CS_HOLD_EN:
  - macro defined: cs continuously low;
  - macro undefined: exactly one cs-high cycle between the words.
